// File: rtl/sound_latch_ctrl.sv
// 68k-to-Z80 sound latch with Z80 bank/DAC registers and a periodic Z80 interrupt.
// Every select is edge-qualified so a level held for a whole bus cycle acts once.
module sound_latch_ctrl #(
  parameter int IRQ_DIV = 3152,
  parameter int BANK_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m68k_latch_cs,
  input  logic [15:0]       m68k_dout,
  input  logic              z80_latch_cs,
  input  logic              z80_latch_clr_cs,
  input  logic              z80_dac_cs,
  input  logic              z80_bank_set_cs,
  input  logic [7:0]        z80_dout,
  input  logic              M1_n,
  input  logic              IORQ_n,
  output logic [7:0]        z80_latch_dout,
  output logic              latch_full,
  output logic              z80_int_n,
  output logic [BANK_W-1:0] z80_bank,
  output logic [7:0]        dac_sample
);

  localparam int CNT_W = (IRQ_DIV > 1) ? $clog2(IRQ_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IRQ_DIV - 1);

  localparam int SEL_WR   = 0;
  localparam int SEL_RD   = 1;
  localparam int SEL_CLR  = 2;
  localparam int SEL_DAC  = 3;
  localparam int SEL_BANK = 4;

  typedef enum logic {IDLE, PEND} irq_state_t;

  logic [4:0]        sel;
  logic [4:0]        sel_reg;
  logic [4:0]        arm_reg;
  logic [4:0]        rise;
  logic              read_end;
  logic              ack;
  logic              tick;
  logic [7:0]        latch_reg;
  logic              full_reg;
  logic [BANK_W-1:0] bank_reg;
  logic [7:0]        dac_reg;
  logic [CNT_W-1:0]  cnt_reg;
  irq_state_t        state_reg;
  logic              int_n_reg;
  logic              unused_hi;

  assign sel = {z80_bank_set_cs, z80_dac_cs, z80_latch_clr_cs, z80_latch_cs, m68k_latch_cs};
  assign unused_hi = ^m68k_dout[15:8];

  // arm_reg blocks a select that was already high at reset release until it has been seen low.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel_reg <= '0;
      arm_reg <= ~sel;
    end else begin
      sel_reg <= sel;
      arm_reg <= arm_reg | ~sel;
    end
  end

  assign rise     = sel & ~sel_reg & arm_reg;
  assign read_end = sel_reg[SEL_RD] & ~sel[SEL_RD];
  assign ack      = ~M1_n & ~IORQ_n;
  assign tick     = (cnt_reg == CNT_LAST);

  // A 68k write beats both a clear and a read-end landing on the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      latch_reg <= 8'h00;
      full_reg  <= 1'b0;
    end else if (rise[SEL_WR]) begin
      latch_reg <= m68k_dout[7:0];
      full_reg  <= 1'b1;
    end else if (rise[SEL_CLR]) begin
      latch_reg <= 8'h00;
      full_reg  <= 1'b0;
    end else if (read_end) begin
      full_reg  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bank_reg <= '0;
      dac_reg  <= 8'h80;
    end else begin
      if (rise[SEL_BANK]) bank_reg <= z80_dout[BANK_W-1:0];
      if (rise[SEL_DAC])  dac_reg  <= z80_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Ticks arriving while pending are dropped; a tick on the ack cycle re-arms the request.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      int_n_reg <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (tick) begin
            state_reg <= PEND;
            int_n_reg <= 1'b0;
          end
        end
        PEND: begin
          if (ack && !tick) begin
            state_reg <= IDLE;
            int_n_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          int_n_reg <= 1'b1;
        end
      endcase
    end
  end

  assign z80_latch_dout = z80_latch_cs ? latch_reg : 8'h00;
  assign latch_full     = full_reg;
  assign z80_int_n      = int_n_reg;
  assign z80_bank       = bank_reg;
  assign dac_sample     = dac_reg;

endmodule
